match_controller: RTL

Top-level match sequencer for the head-soccer game, clocked by the frame clock. It runs the match flow: title screen, kickoff countdown, live play, goal celebration and full time. It drives the `goal_reset` pulse and the freeze enable consumed by both `player` instances and the ball. It also owns the score counters, match clock and winner decision used by the HUD renderer.

---
 rtl/match_controller_if.sv | 30 +++
 rtl/match_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/match_controller_if.sv
// match_controller_if: match-flow bus between the match sequencer and its users.
//   start_btn  - start key level (driven by master)
//   goal_p1/2  - per-frame goal detections (driven by master)
//   game_state, goal_reset, freeze, score_p1/2, time_left, countdown, winner
//              - sequencer outputs (driven by slave)
// master: the side that drives keys/goals and reads the match status.
// slave:  the match_controller itself.
interface match_controller_if;
  logic       start_btn;
  logic       goal_p1;
  logic       goal_p2;
  logic [2:0] game_state;
  logic       goal_reset;
  logic       freeze;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [6:0] time_left;
  logic [7:0] countdown;
  logic [1:0] winner;

  modport master (
    output start_btn, goal_p1, goal_p2,
    input  game_state, goal_reset, freeze, score_p1, score_p2, time_left, countdown, winner
  );

  modport slave (
    input  start_btn, goal_p1, goal_p2,
    output game_state, goal_reset, freeze, score_p1, score_p2, time_left, countdown, winner
  );
endinterface

// File: rtl/match_controller.sv
// match_controller: head-soccer match sequencer (IDLE -> KICKOFF -> PLAY <-> GOAL -> OVER).
// Owns scores, match clock, kickoff/goal countdowns and the winner decision.
// Ports:
//   frame_clk - frame clock, only clock of the block
//   Reset     - synchronous, active-high reset
//   io_bus    - match_controller_if.slave; inputs start_btn/goal_p1/goal_p2,
//               registered outputs game_state, goal_reset, freeze, score_p1/2,
//               time_left, countdown, winner
module match_controller #(
  parameter int unsigned FRAMES_PER_SEC   = 60,
  parameter int unsigned MATCH_SECONDS    = 90,
  parameter int unsigned KICKOFF_FRAMES   = 90,
  parameter int unsigned GOAL_HOLD_FRAMES = 120,
  parameter int unsigned WIN_SCORE        = 7
) (
  input logic               frame_clk,
  input logic               Reset,
  match_controller_if.slave io_bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StKickoff = 3'd1,
    StPlay    = 3'd2,
    StGoal    = 3'd3,
    StOver    = 3'd4
  } state_e;

  localparam int unsigned PW = $clog2(FRAMES_PER_SEC + 1);

  state_e          r_state;
  logic            r_goal_reset;
  logic            r_freeze;
  logic [3:0]      r_score_p1;
  logic [3:0]      r_score_p2;
  logic [6:0]      r_time_left;
  logic [7:0]      r_countdown;
  logic [1:0]      r_winner;
  logic [PW-1:0]   r_presc;
  logic            r_start_q;

  logic            w_start_edge;
  logic            w_goal_p1;
  logic            w_goal_p2;
  logic            w_wrap;
  logic            w_expire;
  logic            w_win_reached;
  logic [3:0]      w_score_p1_inc;
  logic [3:0]      w_score_p2_inc;
  logic [6:0]      w_time_dec;
  logic [1:0]      w_winner_now;

  assign w_start_edge   = io_bus.start_btn & ~r_start_q;
  // A goal is valid only when exactly one side reports it.
  assign w_goal_p1      = io_bus.goal_p1 & ~io_bus.goal_p2;
  assign w_goal_p2      = io_bus.goal_p2 & ~io_bus.goal_p1;
  assign w_wrap         = (r_presc == PW'(FRAMES_PER_SEC - 1));
  assign w_expire       = w_wrap && (r_time_left == 7'd1);
  assign w_win_reached  = (r_score_p1 == 4'(WIN_SCORE)) || (r_score_p2 == 4'(WIN_SCORE));
  assign w_score_p1_inc = (r_score_p1 == 4'd15) ? 4'd15 : r_score_p1 + 4'd1;
  assign w_score_p2_inc = (r_score_p2 == 4'd15) ? 4'd15 : r_score_p2 + 4'd1;
  assign w_time_dec     = (r_time_left == 7'd0) ? 7'd0 : r_time_left - 7'd1;

  always_comb begin
    w_winner_now = 2'b11;
    if (r_score_p1 > r_score_p2)      w_winner_now = 2'b01;
    else if (r_score_p2 > r_score_p1) w_winner_now = 2'b10;
  end

  // The start delay flop keeps sampling through Reset so a key held across
  // reset does not look like a fresh press when reset releases.
  always_ff @(posedge frame_clk) begin
    r_start_q <= io_bus.start_btn;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state      <= StIdle;
      r_goal_reset <= 1'b0;
      r_freeze     <= 1'b1;
      r_score_p1   <= 4'd0;
      r_score_p2   <= 4'd0;
      r_time_left  <= 7'(MATCH_SECONDS);
      r_countdown  <= 8'd0;
      r_winner     <= 2'b00;
      r_presc      <= '0;
    end else begin
      r_goal_reset <= 1'b0;
      case (r_state)
        StIdle: begin
          r_freeze    <= 1'b1;
          r_countdown <= 8'd0;
          if (w_start_edge) begin
            r_score_p1   <= 4'd0;
            r_score_p2   <= 4'd0;
            r_time_left  <= 7'(MATCH_SECONDS);
            r_presc      <= '0;
            r_winner     <= 2'b00;
            r_countdown  <= 8'(KICKOFF_FRAMES - 1);
            r_goal_reset <= 1'b1;
            r_state      <= StKickoff;
          end
        end

        StKickoff: begin
          if (r_countdown == 8'd0) begin
            r_state  <= StPlay;
            r_freeze <= 1'b0;
          end else begin
            r_countdown <= r_countdown - 8'd1;
          end
        end

        StPlay: begin
          r_presc <= w_wrap ? '0 : r_presc + PW'(1);
          if (w_wrap) r_time_left <= w_time_dec;
          // A goal on the expiry frame takes precedence over full time.
          if (w_goal_p1 || w_goal_p2) begin
            if (w_goal_p1) r_score_p1 <= w_score_p1_inc;
            else           r_score_p2 <= w_score_p2_inc;
            r_countdown <= 8'(GOAL_HOLD_FRAMES - 1);
            r_freeze    <= 1'b1;
            r_state     <= StGoal;
          end else if (w_expire) begin
            r_winner <= w_winner_now;
            r_freeze <= 1'b1;
            r_state  <= StOver;
          end
        end

        StGoal: begin
          if (r_countdown != 8'd0) begin
            r_countdown <= r_countdown - 8'd1;
          end else if (w_win_reached || (r_time_left == 7'd0)) begin
            r_winner <= w_winner_now;
            r_state  <= StOver;
          end else begin
            r_countdown  <= 8'(KICKOFF_FRAMES - 1);
            r_goal_reset <= 1'b1;
            r_state      <= StKickoff;
          end
        end

        StOver: begin
          r_freeze    <= 1'b1;
          r_countdown <= 8'd0;
          if (w_start_edge) r_state <= StIdle;
        end

        default: begin
          r_state     <= StIdle;
          r_freeze    <= 1'b1;
          r_countdown <= 8'd0;
        end
      endcase
    end
  end

  assign io_bus.game_state = r_state;
  assign io_bus.goal_reset = r_goal_reset;
  assign io_bus.freeze     = r_freeze;
  assign io_bus.score_p1   = r_score_p1;
  assign io_bus.score_p2   = r_score_p2;
  assign io_bus.time_left  = r_time_left;
  assign io_bus.countdown  = r_countdown;
  assign io_bus.winner     = r_winner;

endmodule
